// File: rtl/controle_cifra_cbc_if.sv
// Bundle of all data, load and handshake signals of the CBC/ECB cipher
// sequencer. clk and rst are kept outside the bundle.
//   master : producer/consumer side (drives blocks, loads, saida_pronta)
//   slave  : the sequencer (drives entrada_pronta, saida, status)
interface controle_cifra_cbc_if #(
  parameter int LARG_CONT = 16
);
  logic [127:0]         chave_in;
  logic                 carrega_chave;
  logic [127:0]         iv_in;
  logic                 carrega_iv;
  logic                 modo_cbc;
  logic [127:0]         bloco_in;
  logic                 entrada_valida;
  logic                 entrada_pronta;
  logic [127:0]         saida;
  logic                 saida_valida;
  logic                 saida_pronta;
  logic                 ocupado;
  logic [LARG_CONT-1:0] contagem;

  modport master (
    output chave_in, carrega_chave, iv_in, carrega_iv, modo_cbc,
           bloco_in, entrada_valida, saida_pronta,
    input  entrada_pronta, saida, saida_valida, ocupado, contagem
  );

  modport slave (
    input  chave_in, carrega_chave, iv_in, carrega_iv, modo_cbc,
           bloco_in, entrada_valida, saida_pronta,
    output entrada_pronta, saida, saida_valida, ocupado, contagem
  );
endinterface

// File: rtl/cifraBloco.sv
// Combinational 128-bit block cipher core driven by controle_cifra_cbc.
// This is a behavioural stand-in with the production core's port list: a
// byte rotation of the block mixed with the key and a fixed whitening
// constant. The constant is chosen so the stand-in reproduces the reference
// known-answer pair (key 5341...414e, block 5056...4552 -> b6bd...6394).
// Replace this file with the real cipher netlist; the sequencer is agnostic.
//   chave   : 128-bit key
//   bloco   : 128-bit input block
//   cifrado : 128-bit output block
module cifraBloco (
  input  logic [127:0] chave,
  input  logic [127:0] bloco,
  output logic [127:0] cifrado
);
  localparam logic [127:0] BRANQUEIO = 128'hb3b9e2408170eb6c301c56c36ba4708a;

  // The rotation keeps key and block non-interchangeable.
  assign cifrado = {bloco[119:0], bloco[127:120]} ^ chave ^ BRANQUEIO;
endmodule

// File: rtl/controle_cifra_cbc.sv
// Sequencer for one combinational cifraBloco instance. Accepts plaintext
// blocks over a valid/ready handshake and encrypts each in ECB or CBC mode
// (selected per block) under a loaded key and IV. The cipher result is
// registered and offered over an output valid/ready handshake.
// The path operando_q/chave_q -> cifraBloco -> saida_q/encadeamento_q is a
// multicycle path of CICLOS_CIFRA cycles: its inputs only change on the
// IDLE->CIFRA edge and its output is sampled CICLOS_CIFRA edges later.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : controle_cifra_cbc_if.slave (key/IV loads, input block handshake,
//          output block handshake, ocupado, contagem)
module controle_cifra_cbc #(
  parameter int CICLOS_CIFRA = 2,
  parameter int LARG_CONT    = 16
) (
  input logic                    clk,
  input logic                    rst,
  controle_cifra_cbc_if.slave    bus
);
  localparam int LARG_ESPERA = (CICLOS_CIFRA > 1) ? $clog2(CICLOS_CIFRA) : 1;
  localparam logic [LARG_ESPERA-1:0] ESPERA_INI = LARG_ESPERA'(CICLOS_CIFRA - 1);

  typedef enum logic [1:0] {IDLE, CIFRA, SAIDA} estado_t;

  estado_t              estado_q;
  logic [127:0]         chave_q;
  logic [127:0]         encadeamento_q;
  logic [127:0]         operando_q;
  logic [127:0]         saida_q;
  logic                 modo_q;
  logic                 saida_valida_q;
  logic [LARG_ESPERA-1:0] espera_q;
  logic [LARG_CONT-1:0] contagem_q;
  logic [127:0]         cifrado;
  logic                 carga;
  logic                 entrada_pronta;
  logic                 aceita;

  cifraBloco u_cifra (
    .chave   (chave_q),
    .bloco   (operando_q),
    .cifrado (cifrado)
  );

  // A pending key/IV load takes priority over a new block in IDLE, so the
  // handshake is refused on that cycle. The rst term keeps ready low while
  // reset is held even though the state already reads IDLE.
  assign carga          = bus.carrega_chave | bus.carrega_iv;
  assign entrada_pronta = (estado_q == IDLE) & ~rst & ~carga;
  assign aceita         = bus.entrada_valida & entrada_pronta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 128-bit datapath registers are reset as well, so saida and
      // the chaining value are defined (zero) straight out of reset.
      estado_q       <= IDLE;
      chave_q        <= '0;
      encadeamento_q <= '0;
      operando_q     <= '0;
      saida_q        <= '0;
      modo_q         <= 1'b0;
      saida_valida_q <= 1'b0;
      espera_q       <= '0;
      contagem_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      unique case (estado_q)
        IDLE: begin
          if (bus.carrega_chave) chave_q <= bus.chave_in;
          if (bus.carrega_iv)    encadeamento_q <= bus.iv_in;
          if (aceita) begin
            operando_q <= bus.modo_cbc ? (bus.bloco_in ^ encadeamento_q)
                                       : bus.bloco_in;
            modo_q     <= bus.modo_cbc;
            espera_q   <= ESPERA_INI;
            estado_q   <= CIFRA;
          end
        end
        CIFRA: begin
          if (espera_q == '0) begin
            saida_q        <= cifrado;
            saida_valida_q <= 1'b1;
            // ECB blocks leave the chaining value untouched.
            if (modo_q) encadeamento_q <= cifrado;
            estado_q       <= SAIDA;
          end else begin
            espera_q <= espera_q - 1'b1;
          end
        end
        SAIDA: begin
          if (bus.saida_pronta) begin
            saida_valida_q <= 1'b0;
            contagem_q     <= contagem_q + 1'b1;
            estado_q       <= IDLE;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign bus.entrada_pronta = entrada_pronta;
  assign bus.saida          = saida_q;
  assign bus.saida_valida   = saida_valida_q;
  assign bus.ocupado        = (estado_q != IDLE);
  assign bus.contagem       = contagem_q;
endmodule

// File: doc/controle_cifra_cbc.md
Name: controle_cifra_cbc

Overview:
Sequencer that drives one instance of the combinational 128-bit block cipher cifraBloco. It accepts a stream of 128-bit plaintext blocks over a valid/ready handshake and encrypts each in ECB or CBC mode under a loaded key and IV. The cipher output is registered and presented over an output valid/ready handshake. The cipher path is treated as a multicycle path of CICLOS_CIFRA cycles.

Parameters:
CICLOS_CIFRA, 2, clock cycles allowed for the combinational cipher path (min 1)
LARG_CONT, 16, width of processed-block counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
chave_in  input  128  key value, sampled when carrega_chave=1
carrega_chave  input  1  load key register (IDLE only)
iv_in  input  128  IV value, sampled when carrega_iv=1
carrega_iv  input  1  load chaining register with iv_in (IDLE only)
modo_cbc  input  1  1=CBC, 0=ECB; sampled with each accepted block
bloco_in  input  128  plaintext block
entrada_valida  input  1  bloco_in valid
entrada_pronta  output  1  block accepted when entrada_valida&entrada_pronta
saida  output  128  ciphertext block
saida_valida  output  1  saida valid
saida_pronta  input  1  consumer ready; transfer when saida_valida&saida_pronta
ocupado  output  1  1 whenever state != IDLE
contagem  output  LARG_CONT  blocks delivered since reset, wraps modulo 2^LARG_CONT

Behaviour:
- Reset (async, immediate): state=IDLE; key, chaining, operand and saida registers = 0; saida_valida=0; entrada_pronta=0 while rst=1; contagem=0; ocupado=0. Reset mid-operation discards the block in flight, and no output is produced for it.
- States: IDLE, CIFRA, SAIDA.
- IDLE: entrada_pronta=1. On handshake, the operand register captures bloco_in XOR chaining (modo_cbc=1) or bloco_in (modo_cbc=0). A wait counter is set to CICLOS_CIFRA-1 and the state moves to CIFRA.
- CIFRA: entrada_pronta=0. The operand and key registers drive cifraBloco. The wait counter decrements each cycle. When it reaches 0, saida is loaded with the cifraBloco output, saida_valida becomes 1, and the state moves to SAIDA.
  - In CBC mode, the chaining register loads the same ciphertext on that edge.
  - In ECB mode, the chaining register is unchanged.
- SAIDA: saida and saida_valida are held stable until saida_pronta=1. On the transfer edge: saida_valida=0, contagem+1, state returns to IDLE. saida keeps its last value.
- Latency: handshake at edge N gives saida_valida=1 after edge N+CICLOS_CIFRA. If saida_pronta is held at 1, the next block can be accepted from cycle N+CICLOS_CIFRA+2. Maximum throughput is one block per CICLOS_CIFRA+2 cycles.
- Key and IV loads:
  - Honoured only in IDLE, and only on a cycle with no input handshake.
  - If carrega_* and entrada_valida are asserted in the same IDLE cycle, the load wins and entrada_pronta=0 that cycle.
  - If carrega_chave and carrega_iv are asserted together, both loads occur.
  - Load requests outside IDLE are ignored. The key and IV used for a block in flight never change.
- The key register is held constant across blocks. cifraBloco inputs change only on the IDLE→CIFRA edge.
- contagem wraps from all-ones to 0 without flagging.
- Each block in a stream may use a different modo_cbc. In CBC mode, the chaining register always holds the IV or the last CBC ciphertext.

Test Plan:
- Reset values: assert rst mid-cycle -> immediately saida=0, saida_valida=0, ocupado=0, contagem=0; entrada_pronta=1 after release.
- ECB single block:
  - Stimulus: key 53414548454253454e4f53494841414e, block 50564543415253494c41544641544552, modo_cbc=0, saida_pronta=1.
  - Response: saida=b6bde4499661f1653f0743cb77a06394 exactly CICLOS_CIFRA edges after accept; contagem=1.
- CBC chain:
  - Stimulus: same key, IV=0. P1=50564543415253494c41544641544552, then P2=e6eba10ad733a22c7346178d36f426c6.
  - Response: both outputs = b6bde4499661f1653f0743cb77a06394; contagem=2.
- Output backpressure:
  - Stimulus: saida_pronta=0 for 10 cycles after saida_valida rises; entrada_valida held at 1.
  - Response: saida stable; entrada_pronta=0; no second accept until the transfer edge.
- Load arbitration:
  - Stimulus: carrega_chave with entrada_valida in IDLE; then carrega_iv during CIFRA.
  - Response: key loaded, block not accepted that cycle; IV load ignored, and the next CBC block still uses the old chaining value.
- Reset mid-CIFRA: assert rst during CIFRA -> saida_valida never rises for that block; state IDLE; contagem=0.
